// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared types and constants for the VGA draw chain
package draw_pkg;

  // Width of the hcount/vcount timing bundle
  localparam int CNT_W = 11;

  // Default colour geometry; modules with another RGB_W build their own constants
  localparam int DEF_RGB_W = 12;
  localparam int DEF_CH_W  = DEF_RGB_W / 3;

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_GRAD   = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_t;

  // Timing bundle carried along every draw stage
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             hblnk;
    logic             vsync;
    logic             vblnk;
  } timing_t;

  // Packs full-scale or zero channels into {R,G,B}; result is right-aligned in 48 bits
  function automatic logic [47:0] rgb_pack(input int ch_w, input logic r, input logic g,
                                           input logic b);
    logic [47:0] m;
    m = (48'd1 << ch_w) - 48'd1;
    return ((({48{r}} & m) << (2 * ch_w)) | (({48{g}} & m) << ch_w) | ({48{b}} & m));
  endfunction

  localparam logic [DEF_RGB_W-1:0] RGB_YELLOW = DEF_RGB_W'(rgb_pack(DEF_CH_W, 1'b1, 1'b1, 1'b0));
  localparam logic [DEF_RGB_W-1:0] RGB_RED    = DEF_RGB_W'(rgb_pack(DEF_CH_W, 1'b1, 1'b0, 1'b0));
  localparam logic [DEF_RGB_W-1:0] RGB_GREEN  = DEF_RGB_W'(rgb_pack(DEF_CH_W, 1'b0, 1'b1, 1'b0));
  localparam logic [DEF_RGB_W-1:0] RGB_BLUE   = DEF_RGB_W'(rgb_pack(DEF_CH_W, 1'b0, 1'b0, 1'b1));
  localparam logic [DEF_RGB_W-1:0] RGB_BLACK  = '0;

endpackage

// File: rtl/draw_timing_delay.sv
// rtl/draw_timing_delay.sv - N-stage register line for the VGA timing bundle
module draw_timing_delay
  import draw_pkg::*;
#(
  parameter int N = 2
) (
  input  logic    pclk,
  input  logic    rst,
  input  timing_t timing_in,
  output timing_t timing_out
);

  timing_t line_q [N];

  // Shift the timing bundle one stage per pixel clock
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= timing_in;
      for (int i = 1; i < N; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign timing_out = line_q[N-1];

endmodule

// File: rtl/draw_background_pattern.sv
// rtl/draw_background_pattern.sv - selectable background generator; DRAW_BACKGROUND_BORDER_EN adds a coloured border
module draw_background_pattern
  import draw_pkg::*;
#(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 600,
  parameter int RGB_W     = 12,
  parameter int TILE_LOG2 = 5,
  parameter int FCNT_W    = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  hcount_in,
  input  logic [CNT_W-1:0]  vcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [1:0]        mode_in,
  input  logic [RGB_W-1:0]  fill_rgb_in,
  input  logic [3:0]        scroll_speed_in,
  output logic [CNT_W-1:0]  hcount_out,
  output logic [CNT_W-1:0]  vcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out,
  output logic [FCNT_W-1:0] frame_cnt_out
);

  localparam int CH_W = RGB_W / 3;

  timing_t t_in, t_out;

  logic              vblnk_q;
  logic              frame_start;
  mode_t             mode_s, mode_nx;
  logic [RGB_W-1:0]  fill_s;
  logic [3:0]        spd_s;
  logic [CNT_W-1:0]  x_off, x_off_nx;
  logic [FCNT_W-1:0] frame_cnt;

  logic [CNT_W-1:0]  hx1, vc1;
  logic              blank1;
  mode_t             mode1;
  logic [RGB_W-1:0]  pat, rgb_nx;

  assign t_in = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};

  draw_timing_delay #(.N(2)) u_delay (
    .pclk       (pclk),
    .rst        (rst),
    .timing_in  (t_in),
    .timing_out (t_out)
  );

  assign hcount_out    = t_out.hcount;
  assign vcount_out    = t_out.vcount;
  assign hsync_out     = t_out.hsync;
  assign hblnk_out     = t_out.hblnk;
  assign vsync_out     = t_out.vsync;
  assign vblnk_out     = t_out.vblnk;
  assign frame_cnt_out = frame_cnt;

  // Frame start is the falling edge of vblnk_in
  assign frame_start = ~vblnk_in & vblnk_q;

  // Bypass the shadows on the frame-start cycle so its own pixel already sees the new frame settings
  always_comb begin
    mode_nx  = mode_s;
    x_off_nx = x_off;
    if (frame_start) begin
      mode_nx  = mode_t'(mode_in);
      x_off_nx = x_off + CNT_W'(spd_s);
    end
  end

  // Shadow registers, scroll offset and frame counter, updated only at frame start
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_q   <= 1'b0;
      mode_s    <= MODE_SOLID;
      fill_s    <= '0;
      spd_s     <= '0;
      x_off     <= '0;
      frame_cnt <= '0;
    end else begin
      vblnk_q <= vblnk_in;
      if (frame_start) begin
        mode_s    <= mode_nx;
        fill_s    <= fill_rgb_in;
        spd_s     <= scroll_speed_in;
        x_off     <= x_off_nx;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Stage 1: scrolled x coordinate, line, blank flag and mode for this pixel
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hx1    <= '0;
      vc1    <= '0;
      blank1 <= 1'b0;
      mode1  <= MODE_SOLID;
    end else begin
      hx1    <= (mode_nx == MODE_GRAD || mode_nx == MODE_SCROLL) ? hcount_in + x_off_nx : hcount_in;
      vc1    <= vcount_in;
      blank1 <= hblnk_in | vblnk_in;
      mode1  <= mode_nx;
    end
  end

  // Background pattern for the stage-1 pixel
  always_comb begin
    pat = fill_s;
    case (mode1)
      MODE_SOLID:              pat = fill_s;
      MODE_CHECK, MODE_SCROLL: pat = (hx1[TILE_LOG2] ^ vc1[TILE_LOG2]) ? ~fill_s : fill_s;
      MODE_GRAD:               pat = {3{hx1[TILE_LOG2+CH_W-1:TILE_LOG2]}};
      default:                 pat = fill_s;
    endcase
  end

`ifdef DRAW_BACKGROUND_BORDER_EN
  localparam logic [47:0] YEL_W = rgb_pack(CH_W, 1'b1, 1'b1, 1'b0);
  localparam logic [47:0] RED_W = rgb_pack(CH_W, 1'b1, 1'b0, 1'b0);
  localparam logic [47:0] GRN_W = rgb_pack(CH_W, 1'b0, 1'b1, 1'b0);
  localparam logic [47:0] BLU_W = rgb_pack(CH_W, 1'b0, 1'b0, 1'b1);
  localparam logic [RGB_W-1:0] C_YELLOW = YEL_W[RGB_W-1:0];
  localparam logic [RGB_W-1:0] C_RED    = RED_W[RGB_W-1:0];
  localparam logic [RGB_W-1:0] C_GREEN  = GRN_W[RGB_W-1:0];
  localparam logic [RGB_W-1:0] C_BLUE   = BLU_W[RGB_W-1:0];

  logic [CNT_W-1:0] hc1;

  // Border needs the unscrolled column
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) hc1 <= '0;
    else     hc1 <= hcount_in;
  end

  // Blanking wins, then the border, then the pattern
  always_comb begin
    rgb_nx = pat;
    if (blank1)                              rgb_nx = '0;
    else if (vc1 == '0)                      rgb_nx = C_YELLOW;
    else if (vc1 == CNT_W'(V_ACTIVE - 1))    rgb_nx = C_RED;
    else if (hc1 == '0)                      rgb_nx = C_GREEN;
    else if (hc1 == CNT_W'(H_ACTIVE - 1))    rgb_nx = C_BLUE;
  end
`else
  // Blanking wins over the pattern
  always_comb begin
    rgb_nx = pat;
    if (blank1) rgb_nx = '0;
  end
`endif

  // Stage 2: register the final colour alongside the twice-delayed timing
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) rgb_out <= '0;
    else     rgb_out <= rgb_nx;
  end

endmodule
